complex_mac_pipe: RTL and testbench
===================================

# complex_mac_pipe

Pipelined, parametrised signed fixed-point complex multiply-accumulate unit with valid/ready handshakes. Per beat it computes a·b or a·conj(b). It either emits each product, or accumulates products across a frame and emits one sum on the frame's last beat. Output is rounded and saturated. It is the streaming successor to the combinational complex multiplier and sits in the DSP datapath between sample buffers and downstream filters and FFT stages.

## Interface
- DATA_WIDTH, 16: signed two's-complement width of every input and output component.
- FRAC_BITS, 15: fractional bits of the operand format (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS); results use the same format.
- GUARD_BITS, 4: extra accumulator headroom bits.
- ACC_WIDTH, 2*DATA_WIDTH+2+GUARD_BITS: accumulator width (derived; do not override).
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high (already decided).
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when valid and ready are both high.
- a_re_i, a_im_i, b_re_i, b_im_i  in  DATA_WIDTH each  signed operands.
- in_conj_i  in  1  use conj(b).
- in_acc_i  in  1  accumulate mode for this beat.
- in_last_i  in  1  final beat of an accumulate frame; ignored when in_acc_i=0.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts.
- c_re_o, c_im_o  out  DATA_WIDTH each  signed result.
- c_sat_o  out  1  either component saturated on this result.

## Operation
- S1 registers the operands, sign-extended to DATA_WIDTH+1. When conj=1, b_im is negated, so -(-2^(DATA_WIDTH-1)) is exact. Control flags are registered alongside.
- S2 registers the four full-precision signed products: ac, bd, ad, bc.
- S3 forms re=ac-bd and im=ad+bc at ACC_WIDTH bits.
  - acc=0: the value is round/saturated into the output register. The accumulator is untouched.
  - acc=1, last=0: the value is added to the accumulator. No output beat is produced.
  - acc=1, last=1: accumulator+value is round/saturated to the output and the accumulator clears to 0.
- Rounding: add 2^(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS (round half up).
- Saturation: clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. c_sat_o=1 if either component clamped.
- The accumulator wraps two's-complement beyond 2^GUARD_BITS full-scale beats. This is defined behaviour and is not flagged.
- Interleaving acc=0 beats inside a frame is legal. They pass through, and the pending sum is preserved.

## Timing
- Reset values: out_valid_o=0, c_re_o=c_im_o=0, c_sat_o=0, accumulator=0, all stage valids=0.
- Latency: a beat accepted at edge N produces out_valid_o from edge N+3, given no stall.
- Throughput: 1 beat/cycle.
- Global enable: en = !out_valid_o || out_ready_i.
  - in_ready_o = en, combinational.
  - All stages advance only when en=1.
  - Stalls are lossless and order-preserving.
- out_valid_o, c_*_o and c_sat_o stay stable while out_valid_o=1 and out_ready_i=0.
- Non-last accumulate beats create bubbles: out_valid_o falls if the next S3 beat produces no output.
- Reset mid-frame discards the partial sum and all in-flight beats. The first beat after reset deassertion begins a new frame.
- Output accept and new S3 result in the same cycle: the output register reloads, with no bubble.

## Structure
- Package complex_pkg:
  - localparam helpers for ACC_WIDTH.
  - A struct for the complex component pair.
  - A per-stage control struct {valid, conj, acc, last}.
- Sub-module cmac_round_sat (ACC_WIDTH in, DATA_WIDTH out, FRAC_BITS): rounding plus saturation with a sat flag. It is instantiated twice, for re and im.
- Top-level contents: the pipeline, the accumulator and the handshake.

## Test plan
- Plain mode: a=(0x4000,0x4000), b=(0x4000,0x0000), conj=0 -> c=(0x2000,0x2000), sat=0, 3 cycles after accept.
- Conjugate mode: a=(0x4000,0x4000), b=(0x4000,0x4000), conj=1 -> c=(0x4000,0x0000).
- Saturation:
  - a=(0x8000,0), b=(0x8000,0) -> c=(0x7FFF,0x0000), sat=1.
  - a=(0x8000,0), b=(0x7FFF,0) -> c_re=0x8001, sat=0.
- Accumulate frame: 3 beats a=(0x4000,0), b=(0x4000,0), acc=1, last on the 3rd -> exactly one output c=(0x6000,0). An immediately following single-beat frame with the same operands -> c=(0x2000,0), showing the accumulator cleared.
- Backpressure: 20-beat random stream, out_ready_i low for 5 cycles mid-stream -> in_ready_o low during the stall, outputs stable, all 20 results in order and bit-exact against the model.
- Reset mid-frame: assert rst_i after 2 of 3 accumulate beats. Then send a 1-beat frame of 0x2000 product -> out=(0x2000,0), and no stale output appears.

Source files
------------

// File: rtl/complex_pkg.sv
// Shared types and width helpers for the streaming complex MAC datapath.
package complex_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_BITS  = 15;
  localparam int DEF_GUARD_BITS = 4;

  function automatic int acc_width(input int data_width, input int guard_bits);
    return 2 * data_width + 2 + guard_bits;
  endfunction

  localparam int DEF_ACC_WIDTH = acc_width(DEF_DATA_WIDTH, DEF_GUARD_BITS);

  typedef struct packed {
    logic signed [DEF_DATA_WIDTH-1:0] re;
    logic signed [DEF_DATA_WIDTH-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic valid;
    logic conj;
    logic acc;
    logic last;
  } stage_ctrl_t;

endpackage

// File: rtl/cmac_round_sat.sv
// Round-half-up by FRAC_BITS and clamp a wide signed value to OUT_WIDTH bits.
module cmac_round_sat #(
  parameter int IN_WIDTH  = 38,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        sat
);

  localparam int XW = IN_WIDTH + 1;

  localparam logic signed [XW-1:0] HALF =
    {{(XW-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [XW-1:0] MAXV =
    {{(XW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV =
    {{(XW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // One extra bit so the rounding bias can never wrap the input.
  logic signed [XW-1:0] biased;
  logic signed [XW-1:0] shifted;

  assign biased  = {din[IN_WIDTH-1], din} + HALF;
  assign shifted = biased >>> FRAC_BITS;

  always_comb begin
    dout = shifted[OUT_WIDTH-1:0];
    sat  = 1'b0;
    if (shifted > MAXV) begin
      dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      sat  = 1'b1;
    end else if (shifted < MINV) begin
      dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/complex_mac_pipe.sv
// Pipelined complex multiply / multiply-accumulate with a single global stall enable.
module complex_mac_pipe
  import complex_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int GUARD_BITS = DEF_GUARD_BITS,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, GUARD_BITS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] a_re_i,
  input  logic [DATA_WIDTH-1:0] a_im_i,
  input  logic [DATA_WIDTH-1:0] b_re_i,
  input  logic [DATA_WIDTH-1:0] b_im_i,
  input  logic                  in_conj_i,
  input  logic                  in_acc_i,
  input  logic                  in_last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] c_re_o,
  output logic [DATA_WIDTH-1:0] c_im_o,
  output logic                  c_sat_o
);

  localparam int OW = DATA_WIDTH + 1;
  localparam int PW = 2 * OW;
  localparam int XW = ACC_WIDTH - PW;

  logic en;

  stage_ctrl_t s1_ctrl, s2_ctrl, s3_ctrl;
  logic signed [OW-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im;
  logic signed [PW-1:0] s2_ac, s2_bd, s2_ad, s2_bc;
  logic signed [ACC_WIDTH-1:0] s3_re, s3_im;
  logic signed [ACC_WIDTH-1:0] acc_re, acc_im;
  logic signed [ACC_WIDTH-1:0] sum_re, sum_im;
  logic signed [OW-1:0] b_im_x;
  logic [DATA_WIDTH-1:0] rs_re, rs_im;
  logic sat_re, sat_im, emit;

  assign en         = !out_valid_o || out_ready_i;
  assign in_ready_o = en;

  // Widening before negation keeps -(-full scale) exact under conjugation.
  assign b_im_x = $signed({b_im_i[DATA_WIDTH-1], b_im_i});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_ctrl <= '0;
      s1_a_re <= '0;
      s1_a_im <= '0;
      s1_b_re <= '0;
      s1_b_im <= '0;
    end else if (en) begin
      s1_ctrl <= '{valid: in_valid_i, conj: in_conj_i, acc: in_acc_i,
                   last: in_acc_i & in_last_i};
      s1_a_re <= $signed({a_re_i[DATA_WIDTH-1], a_re_i});
      s1_a_im <= $signed({a_im_i[DATA_WIDTH-1], a_im_i});
      s1_b_re <= $signed({b_re_i[DATA_WIDTH-1], b_re_i});
      s1_b_im <= in_conj_i ? -b_im_x : b_im_x;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_ctrl <= '0;
      s2_ac   <= '0;
      s2_bd   <= '0;
      s2_ad   <= '0;
      s2_bc   <= '0;
    end else if (en) begin
      s2_ctrl <= s1_ctrl;
      s2_ac   <= s1_a_re * s1_b_re;
      s2_bd   <= s1_a_im * s1_b_im;
      s2_ad   <= s1_a_re * s1_b_im;
      s2_bc   <= s1_a_im * s1_b_re;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s3_ctrl <= '0;
      s3_re   <= '0;
      s3_im   <= '0;
    end else if (en) begin
      s3_ctrl <= s2_ctrl;
      s3_re   <= {{XW{s2_ac[PW-1]}}, s2_ac} - {{XW{s2_bd[PW-1]}}, s2_bd};
      s3_im   <= {{XW{s2_ad[PW-1]}}, s2_ad} + {{XW{s2_bc[PW-1]}}, s2_bc};
    end
  end

  assign sum_re = s3_ctrl.acc ? acc_re + s3_re : s3_re;
  assign sum_im = s3_ctrl.acc ? acc_im + s3_im : s3_im;
  assign emit   = s3_ctrl.valid && (!s3_ctrl.acc || s3_ctrl.last);

  cmac_round_sat #(
    .IN_WIDTH (ACC_WIDTH),
    .OUT_WIDTH(DATA_WIDTH),
    .FRAC_BITS(FRAC_BITS)
  ) u_rs_re (
    .din (sum_re),
    .dout(rs_re),
    .sat (sat_re)
  );

  cmac_round_sat #(
    .IN_WIDTH (ACC_WIDTH),
    .OUT_WIDTH(DATA_WIDTH),
    .FRAC_BITS(FRAC_BITS)
  ) u_rs_im (
    .din (sum_im),
    .dout(rs_im),
    .sat (sat_im)
  );

  // Non-last accumulate beats only update the running sum; pass-through beats leave it alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (en && s3_ctrl.valid && s3_ctrl.acc) begin
      if (s3_ctrl.last) begin
        acc_re <= '0;
        acc_im <= '0;
      end else begin
        acc_re <= sum_re;
        acc_im <= sum_im;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      c_re_o      <= '0;
      c_im_o      <= '0;
      c_sat_o     <= 1'b0;
    end else if (en) begin
      out_valid_o <= emit;
      if (emit) begin
        c_re_o  <= rs_re;
        c_im_o  <= rs_im;
        c_sat_o <= sat_re | sat_im;
      end
    end
  end

endmodule

// File: tb/tb_complex_mac_pipe.sv
// Directed bench for complex_mac_pipe: modes, saturation, frames, backpressure, reset.
module tb_complex_mac_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [15:0] a_re_i = '0, a_im_i = '0, b_re_i = '0, b_im_i = '0;
  logic        in_conj_i = 1'b0, in_acc_i = 1'b0, in_last_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [15:0] c_re_o, c_im_o;
  logic        c_sat_o;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  complex_mac_pipe dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_re_i(a_re_i), .a_im_i(a_im_i), .b_re_i(b_re_i), .b_im_i(b_im_i),
    .in_conj_i(in_conj_i), .in_acc_i(in_acc_i), .in_last_i(in_last_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .c_re_o(c_re_o), .c_im_o(c_im_o), .c_sat_o(c_sat_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (out_valid_o && out_ready_i) n_out++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent reference: {sat, re, im} of rounded/saturated a*b or a*conj(b).
  function automatic logic [32:0] model(input logic signed [15:0] ar, ai, br, bi,
                                        input logic cj);
    longint bim, re, im, rr, ri;
    logic sr, si;
    bim = cj ? -longint'(bi) : longint'(bi);
    re = longint'(ar) * longint'(br) - longint'(ai) * bim;
    im = longint'(ar) * bim + longint'(ai) * longint'(br);
    rr = (re + 64'sd16384) >>> 15;
    ri = (im + 64'sd16384) >>> 15;
    sr = (rr > 32767) || (rr < -32768);
    si = (ri > 32767) || (ri < -32768);
    if (rr > 32767) rr = 32767;
    if (rr < -32768) rr = -32768;
    if (ri > 32767) ri = 32767;
    if (ri < -32768) ri = -32768;
    return {sr | si, rr[15:0], ri[15:0]};
  endfunction

  task automatic drive(input logic [15:0] ar, ai, br, bi, input logic cj, ac, ls);
    @(negedge clk_i);
    a_re_i = ar; a_im_i = ai; b_re_i = br; b_im_i = bi;
    in_conj_i = cj; in_acc_i = ac; in_last_i = ls;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [15:0] er, ei, input logic es);
    int lat;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i);
      if (out_valid_o) begin
        lat = k;
        break;
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'd3);
    chk({tag, " re"}, 64'(c_re_o), 64'(er));
    chk({tag, " im"}, 64'(c_im_o), 64'(ei));
    chk({tag, " sat"}, 64'(c_sat_o), 64'(es));
    @(negedge clk_i);
    chk({tag, " valid drop"}, 64'(out_valid_o), 64'd0);
  endtask

  logic [15:0] sar[20], sai[20], sbr[20], sbi[20];
  logic        scj[20];
  logic [32:0] sexp[20];
  logic [32:0] held;
  logic        stalled_prev;
  int          sent, rcv, cyc, n0;

  initial begin
    // reset values
    repeat (2) @(negedge clk_i);
    chk("rst out_valid", 64'(out_valid_o), 64'd0);
    chk("rst c_re", 64'(c_re_o), 64'd0);
    chk("rst c_im", 64'(c_im_o), 64'd0);
    chk("rst c_sat", 64'(c_sat_o), 64'd0);
    chk("rst in_ready", 64'(in_ready_o), 64'd1);
    rst_i = 1'b0;

    drive(16'h4000, 16'h4000, 16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_result("plain", 16'h2000, 16'h2000, 1'b0);

    drive(16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b1, 1'b0, 1'b0);
    check_result("conj", 16'h4000, 16'h0000, 1'b0);

    drive(16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_result("sat pos", 16'h7FFF, 16'h0000, 1'b1);

    drive(16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_result("near neg", 16'h8001, 16'h0000, 1'b0);

    // conj of full-scale negative b_im must not overflow
    drive(16'h0000, 16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b0, 1'b0);
    check_result("conj minfs", 16'h7FFF, 16'h0000, 1'b1);

    // 3-beat accumulate frame, then a 1-beat frame
    n0 = n_out;
    drive(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b0);
    drive(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b0);
    drive(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b1);
    check_result("acc3", 16'h6000, 16'h0000, 1'b0);
    chk("acc3 one output", 64'(n_out - n0), 64'd1);
    drive(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b1);
    check_result("acc1 cleared", 16'h2000, 16'h0000, 1'b0);

    // pass-through beat inside a frame leaves the pending sum alone
    drive(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b0);
    drive(16'h2000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_result("interleave pass", 16'h1000, 16'h0000, 1'b0);
    drive(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b1);
    check_result("interleave sum", 16'h4000, 16'h0000, 1'b0);

    // backpressure stream
    for (int i = 0; i < 20; i++) begin
      sar[i] = 16'($urandom);
      sai[i] = 16'($urandom);
      sbr[i] = 16'($urandom);
      sbi[i] = 16'($urandom);
      scj[i] = 1'($urandom);
    end
    sar[5] = 16'h8000; sai[5] = 16'h8000; sbr[5] = 16'h8000; sbi[5] = 16'h7FFF; scj[5] = 1'b1;
    for (int i = 0; i < 20; i++)
      sexp[i] = model(sar[i], sai[i], sbr[i], sbi[i], scj[i]);
    in_acc_i = 1'b0; in_last_i = 1'b0;
    sent = 0; rcv = 0; cyc = 0; stalled_prev = 1'b0; held = '0;
    while (rcv < 20 && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      out_ready_i = !(cyc >= 6 && cyc < 11);
      if (sent < 20) begin
        in_valid_i = 1'b1;
        a_re_i = sar[sent]; a_im_i = sai[sent];
        b_re_i = sbr[sent]; b_im_i = sbi[sent];
        in_conj_i = scj[sent];
      end else begin
        in_valid_i = 1'b0;
      end
      #1;
      if (out_valid_o && !out_ready_i) begin
        chk("bp in_ready low", 64'(in_ready_o), 64'd0);
        if (stalled_prev) chk("bp hold", 64'({c_sat_o, c_re_o, c_im_o}), 64'(held));
        held = {c_sat_o, c_re_o, c_im_o};
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (out_valid_o && out_ready_i) begin
        chk($sformatf("bp beat %0d", rcv), 64'({c_sat_o, c_re_o, c_im_o}), 64'(sexp[rcv]));
        rcv++;
      end
      if (in_valid_i && in_ready_o) sent++;
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    chk("bp count", 64'(rcv), 64'd20);

    // reset in the middle of a frame
    repeat (4) @(negedge clk_i);
    drive(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b0);
    drive(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("midrst out_valid", 64'(out_valid_o), 64'd0);
    chk("midrst c_re", 64'(c_re_o), 64'd0);
    rst_i = 1'b0;
    n0 = n_out;
    repeat (5) @(negedge clk_i);
    chk("midrst no stale", 64'(n_out - n0), 64'd0);
    drive(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b1);
    check_result("post rst frame", 16'h2000, 16'h0000, 1'b0);
    chk("post rst one output", 64'(n_out - n0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
